jzjpcc_fetch: RTL and testbench

// - Fetch stage of the jzjpcc 5-stage pipeline; sits directly upstream of jzjpcc_decode.
// - Owns the PC register and drives the synchronous-read instruction memory address.
// - Registers instruction/PC into the decode stage; applies stall, flush and decode-resolved control transfers.
// - Inserts NOP bubbles on wrong-path fetches.

---
 rtl/jzjpcc_fetch.sv | 78 +++++++
 tb/tb_jzjpcc_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jzjpcc_fetch.sv
// Fetch stage of the jzjpcc pipeline: PC register, instruction memory address, decode-stage registers.
// Optional performance counters are enabled with `define JZJPCC_FETCH_COUNTERS_EN.
module jzjpcc_fetch #(
    parameter int unsigned PC_MAX_B = 15,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_MAX_B-2:0] instMemAddr,
    input  logic [29:0]         instMemData,
    input  logic                stall_fetch,
    input  logic                flush_decode,
    input  logic                pcCTWriteEnable,
    input  logic [PC_MAX_B-2:0] controlTransferNewPC,
    output logic [29:0]         instruction_decode,
`ifdef JZJPCC_FETCH_COUNTERS_EN
    output logic [PC_MAX_B-2:0] currentPC_decode,
    output logic [31:0]         fetchCount,
    output logic [31:0]         bubbleCount
`else
    output logic [PC_MAX_B-2:0] currentPC_decode
`endif
);

    localparam int unsigned PC_W = PC_MAX_B - 1;
    localparam logic [PC_W-1:0] RESET_WORD = RESET_PC[PC_MAX_B:2];
    localparam logic [29:0] NOP = 30'h0000004;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            squash;

    // Next fetch address; also drives the memory so its registered output tracks pc.
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (reset) begin
            pc_next = RESET_WORD;
        end else if (stall_fetch) begin
            pc_next = pc;
        end else if (pcCTWriteEnable) begin
            pc_next = controlTransferNewPC;
        end
    end

    assign instMemAddr = pc_next;
    assign squash      = flush_decode | pcCTWriteEnable;

    always_ff @(posedge clock) begin
        pc <= pc_next;
    end

    // Decode registers; the slot fetched alongside a redirect is on the wrong path.
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction_decode <= NOP;
            currentPC_decode   <= RESET_WORD;
        end else if (!stall_fetch) begin
            instruction_decode <= squash ? NOP : instMemData;
            currentPC_decode   <= pc;
        end
    end

`ifdef JZJPCC_FETCH_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchCount  <= 32'd0;
            bubbleCount <= 32'd0;
        end else if (!stall_fetch) begin
            if (squash) begin
                bubbleCount <= bubbleCount + 32'd1;
            end else begin
                fetchCount <= fetchCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// Directed table-driven bench for jzjpcc_fetch; memory word[i] = i<<2|3, so its [31:2] equals i.
`timescale 1ns/1ps
module tb_jzjpcc_fetch;

    localparam int unsigned PCW = 14;
    localparam logic [29:0] NOP = 30'h0000004;
    localparam int NV = 30;

    logic           clock = 1'b0;
    logic           reset, stall_fetch, flush_decode, pcCTWriteEnable;
    logic [PCW-1:0] instMemAddr, controlTransferNewPC, currentPC_decode;
    logic [29:0]    instMemData, instruction_decode;
`ifdef JZJPCC_FETCH_COUNTERS_EN
    logic [31:0]    fetchCount, bubbleCount;
    int unsigned    m_fetch = 0, m_bubble = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    jzjpcc_fetch #(.PC_MAX_B(15), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .instMemAddr(instMemAddr), .instMemData(instMemData),
        .stall_fetch(stall_fetch), .flush_decode(flush_decode),
        .pcCTWriteEnable(pcCTWriteEnable), .controlTransferNewPC(controlTransferNewPC),
        .instruction_decode(instruction_decode),
`ifdef JZJPCC_FETCH_COUNTERS_EN
        .currentPC_decode(currentPC_decode),
        .fetchCount(fetchCount), .bubbleCount(bubbleCount)
`else
        .currentPC_decode(currentPC_decode)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory
    always @(posedge clock) instMemData <= 30'(instMemAddr);

    typedef struct {
        logic           rst, stall, flush, ct;
        logic [PCW-1:0] tgt;
        logic [PCW-1:0] addr;
        logic [29:0]    inst;
        logic [PCW-1:0] pc;
    } vec_t;

    vec_t tv [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        @(negedge clock);
        reset = v.rst; stall_fetch = v.stall; flush_decode = v.flush;
        pcCTWriteEnable = v.ct; controlTransferNewPC = v.tgt;
        #1;
        check("instMemAddr", idx, 32'(instMemAddr), 32'(v.addr));
        @(posedge clock);
        #1;
        check("instruction_decode", idx, 32'(instruction_decode), 32'(v.inst));
        check("currentPC_decode", idx, 32'(currentPC_decode), 32'(v.pc));
`ifdef JZJPCC_FETCH_COUNTERS_EN
        if (v.rst) begin
            m_fetch = 0; m_bubble = 0;
        end else if (!v.stall) begin
            if (v.flush || v.ct) m_bubble++;
            else m_fetch++;
        end
        check("fetchCount", idx, fetchCount, m_fetch);
        check("bubbleCount", idx, bubbleCount, m_bubble);
`endif
    endtask

    initial begin
        reset = 1'b1; stall_fetch = 1'b0; flush_decode = 1'b0;
        pcCTWriteEnable = 1'b0; controlTransferNewPC = '0;

        //          rst   stl   fls   ct    tgt       addr      inst      pc
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, NOP,      14'h0000};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, NOP,      14'h0000};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0001, 30'h0000, 14'h0000};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0002, 30'h0001, 14'h0001};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0003, 30'h0002, 14'h0002};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0004, 30'h0003, 14'h0003};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0005, 30'h0004, 14'h0004};
        // redirect to 0x40 while pc=5
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0040, 14'h0040, NOP,      14'h0005};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0041, 30'h0040, 14'h0040};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0006, 14'h0006, NOP,      14'h0041};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0007, 30'h0006, 14'h0006};
        // three-cycle stall with pc=7
        tv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 14'h0007, 30'h0006, 14'h0006};
        tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 14'h0007, 30'h0006, 14'h0006};
        tv[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 14'h0007, 30'h0006, 14'h0006};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0008, 30'h0007, 14'h0007};
        tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0009, 30'h0008, 14'h0008};
        // stall beats redirect and flush; redirect reasserted on release
        tv[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 14'h0020, 14'h0009, 30'h0008, 14'h0008};
        tv[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 14'h0020, 14'h0009, 30'h0008, 14'h0008};
        tv[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0020, 14'h0020, NOP,      14'h0009};
        tv[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0021, 30'h0020, 14'h0020};
        // PC wrap at 0x3FFF
        tv[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h3FFE, 14'h3FFE, NOP,      14'h0021};
        tv[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h3FFF, 30'h3FFE, 14'h3FFE};
        tv[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, 30'h3FFF, 14'h3FFF};
        tv[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0001, 30'h0000, 14'h0000};
        // single-cycle flush
        tv[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h0002, NOP,      14'h0001};
        tv[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0003, 30'h0002, 14'h0002};
        // reset mid-stream at 0x123, with stall and redirect also asserted
        tv[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0123, 14'h0123, NOP,      14'h0003};
        tv[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0124, 30'h0123, 14'h0123};
        tv[28] = '{1'b1, 1'b1, 1'b0, 1'b1, 14'h0055, 14'h0000, NOP,      14'h0000};
        tv[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0001, 30'h0000, 14'h0000};

        for (int i = 0; i < NV; i++) step(i, tv[i]);

        // Held flush: one bubble per cycle, pc still advances
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h0002, NOP, 14'h0001};
            step(100, v);
            v = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h0003, NOP, 14'h0002};
            step(101, v);
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0004, 30'h0003, 14'h0003};
            step(102, v);
        end

        // Back-to-back redirects: every wrong-path slot squashed
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0100, 14'h0100, NOP, 14'h0004};
            step(110, v);
            v = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0200, 14'h0200, NOP, 14'h0100};
            step(111, v);
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0201, 30'h0200, 14'h0200};
            step(112, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
